counter_mod6: RTL and testbench

//   Single BCD-style modulo-6 down-counter digit (values 5..0), used as the

---
 rtl/counter_mod6_pkg.sv | 9 +
 rtl/counter_mod6_if.sv | 12 +
 rtl/counter_mod6.sv | 24 ++
 tb/tb_counter_mod6.sv | 80 ++++++++
 4 files changed

// File: rtl/counter_mod6_pkg.sv
// counter_mod6_pkg: shared timer digit constants, digit type and load saturation helper
package counter_mod6_pkg;
    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] MAX_DIGIT = 4'd5;
    typedef logic [DIGIT_W-1:0] digit_t;
    function automatic digit_t sat_digit(input digit_t v);
        return (v > MAX_DIGIT) ? MAX_DIGIT : v;
    endfunction
endpackage

// File: rtl/counter_mod6_if.sv
// counter_mod6_if: load/count controls and digit status of one timer digit
interface counter_mod6_if;
    import counter_mod6_pkg::*;
    logic   loadn;
    logic   en;
    digit_t data;
    digit_t digit;
    logic   zero;
    logic   tc;
    modport master(output loadn, en, data, input digit, zero, tc);
    modport slave(input loadn, en, data, output digit, zero, tc);
endinterface

// File: rtl/counter_mod6.sv
// counter_mod6: loadable modulo-6 down-counter digit with borrow-out and zero detect
module counter_mod6
    import counter_mod6_pkg::*;
(
    input logic            clock,
    input logic            clearn,
    counter_mod6_if.slave  bus
);
    digit_t digit_q, digit_d;
    // next digit: load beats count, count wraps 0 to MAX_DIGIT
    always_comb begin
        digit_d = !bus.loadn ? sat_digit(bus.data) :
                  bus.en     ? ((digit_q == '0) ? MAX_DIGIT : digit_q - 4'd1) :
                               digit_q;
    end
    // digit register, cleared asynchronously
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) digit_q <= '0;
        else         digit_q <= digit_d;
    end
    assign bus.digit = digit_q;
    assign bus.zero  = (digit_q == '0);
    assign bus.tc    = bus.en && (digit_q == '0);
endmodule

// File: tb/tb_counter_mod6.sv
// tb_counter_mod6: scoreboard bench for the modulo-6 down-counter digit
module tb_counter_mod6;
    import counter_mod6_pkg::*;
    logic clock  = 1'b0;
    logic clearn = 1'b0;
    counter_mod6_if bus();
    counter_mod6 dut(.clock(clock), .clearn(clearn), .bus(bus));
    always #5 clock = ~clock;
    int     n_run  = 0;
    int     n_fail = 0;
    digit_t m;
    digit_t sb[$];
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic step(input logic ld, input logic e, input digit_t d, input string tag);
        digit_t exp_d;
        bus.loadn = ld;
        bus.en    = e;
        bus.data  = d;
        #1;
        check({tag, ".tc"}, {7'd0, bus.tc}, {7'd0, e && (m == 4'd0)});
        check({tag, ".zero"}, {7'd0, bus.zero}, {7'd0, m == 4'd0});
        if (!ld)    m = (d > 4'd5) ? 4'd5 : d;
        else if (e) m = (m == 4'd0) ? 4'd5 : m - 4'd1;
        sb.push_back(m);
        @(posedge clock);
        #1;
        exp_d = sb.pop_front();
        check({tag, ".digit"}, {4'd0, bus.digit}, {4'd0, exp_d});
    endtask
    initial begin
        bus.loadn = 1'b1;
        bus.en    = 1'b1;
        bus.data  = 4'd0;
        m         = 4'd0;
        #3;
        check("rst.digit", {4'd0, bus.digit}, 8'd0);
        check("rst.zero", {7'd0, bus.zero}, 8'd1);
        check("rst.tc_en1", {7'd0, bus.tc}, 8'd1);
        bus.en = 1'b0;
        #1;
        check("rst.tc_en0", {7'd0, bus.tc}, 8'd0);
        bus.en = 1'b1;
        @(posedge clock);
        #1;
        check("rst.hold", {4'd0, bus.digit}, 8'd0);
        clearn = 1'b1;
        step(1'b0, 1'b0, 4'd3, "ld3");
        step(1'b0, 1'b0, 4'd6, "ld6");
        step(1'b0, 1'b0, 4'd15, "ld15");
        step(1'b0, 1'b0, 4'd0, "ld0");
        step(1'b0, 1'b0, 4'd5, "ld5");
        repeat (7) step(1'b1, 1'b1, 4'd0, "cnt");
        repeat (10) step(1'b1, 1'b0, 4'd9, "hold");
        step(1'b0, 1'b1, 4'd2, "ldwin");
        repeat (2) step(1'b1, 1'b1, 4'd0, "cnt2");
        #2;
        clearn = 1'b0;
        #1;
        m = 4'd0;
        check("aclr.digit", {4'd0, bus.digit}, 8'd0);
        check("aclr.zero", {7'd0, bus.zero}, 8'd1);
        check("aclr.tc", {7'd0, bus.tc}, 8'd1);
        @(posedge clock);
        #1;
        check("aclr.hold", {4'd0, bus.digit}, 8'd0);
        clearn = 1'b1;
        step(1'b1, 1'b1, 4'd0, "rel");
        step(1'b1, 1'b1, 4'd0, "rel2");
        for (int i = 0; i < 40; i++)
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), "rnd");
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
